accel_sample_scheduler: RTL



---
 rtl/accel_pkg.sv | 24 ++
 rtl/sat_counter.sv | 23 ++
 rtl/accel_sample_scheduler.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/accel_pkg.sv
// Shared types and constants for the accelerometer sample scheduler.
package accel_pkg;

    localparam int unsigned AXIS_W          = 16;
    localparam int unsigned TIMEOUT_DEFAULT = 50000;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StReq   = 2'd1,
        StWait  = 2'd2,
        StLatch = 2'd3
    } state_e;

    // Mean of two samples; the sum is formed at AXIS_W+1 bits so it cannot overflow.
    function automatic logic signed [AXIS_W-1:0] avg2(input logic signed [AXIS_W-1:0] a,
                                                      input logic signed [AXIS_W-1:0] b);
        logic signed [AXIS_W:0] sum;
        logic signed [AXIS_W:0] half;
        sum  = $signed({a[AXIS_W-1], a}) + $signed({b[AXIS_W-1], b});
        half = sum >>> 1;
        return half[AXIS_W-1:0];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (clear) begin
            count_q <= '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/accel_sample_scheduler.sv
// Issues one accelerometer read per sample tick, with retry/timeout/overrun accounting.
// Optional build macro ACCEL_AVG_EN: outputs become the mean of the previous and new sample.
module accel_sample_scheduler
    import accel_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int unsigned RETRY_MAX      = 2,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sample_tick,
    output logic                     rd_req,
    input  logic                     rd_ack,
    input  logic                     rd_done,
    input  logic                     rd_err,
    input  logic signed [AXIS_W-1:0] x_in,
    input  logic signed [AXIS_W-1:0] y_in,
    input  logic signed [AXIS_W-1:0] z_in,
    output logic signed [AXIS_W-1:0] x_out,
    output logic signed [AXIS_W-1:0] y_out,
    output logic signed [AXIS_W-1:0] z_out,
    output logic                     sample_valid,
    output logic                     sample_fail,
    output logic                     busy,
    output logic [CNT_W-1:0]         overrun_cnt,
    output logic [CNT_W-1:0]         fault_cnt
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned RTY_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(RETRY_MAX);

    state_e                    state_q;
    logic [TMR_W-1:0]          timer_q;
    logic [RTY_W-1:0]          retry_q;
    logic                      rd_req_q;
    logic                      sample_valid_q;
    logic                      sample_fail_q;
    logic signed [AXIS_W-1:0]  x_q, y_q, z_q;
    logic signed [AXIS_W-1:0]  x_new, y_new, z_new;

    logic timed_out;
    logic capture;
    logic attempt_failed;
    logic retries_left;
    logic fault_inc;
    logic overrun_inc;

    assign timed_out    = (timer_q == TMR_LAST);
    assign retries_left = (retry_q < RTY_LAST);
    // Error beats done in the same cycle; done beats a coincident timeout.
    assign capture      = (state_q == StWait) && rd_done && !rd_err;
    assign attempt_failed = ((state_q == StReq) && !rd_ack && timed_out) ||
                            ((state_q == StWait) && (rd_err || (!rd_done && timed_out)));
    assign fault_inc    = attempt_failed && !retries_left;
    assign overrun_inc  = sample_tick && (state_q != StIdle);

`ifdef ACCEL_AVG_EN
    logic                     have_prev_q;
    logic signed [AXIS_W-1:0] x_prev_q, y_prev_q, z_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            have_prev_q <= 1'b0;
            x_prev_q    <= '0;
            y_prev_q    <= '0;
            z_prev_q    <= '0;
        end else if (capture) begin
            have_prev_q <= 1'b1;
            x_prev_q    <= x_in;
            y_prev_q    <= y_in;
            z_prev_q    <= z_in;
        end
    end

    assign x_new = have_prev_q ? avg2(x_prev_q, x_in) : x_in;
    assign y_new = have_prev_q ? avg2(y_prev_q, y_in) : y_in;
    assign z_new = have_prev_q ? avg2(z_prev_q, z_in) : z_in;
`else
    assign x_new = x_in;
    assign y_new = y_in;
    assign z_new = z_in;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            timer_q        <= '0;
            retry_q        <= '0;
            rd_req_q       <= 1'b0;
            sample_valid_q <= 1'b0;
            sample_fail_q  <= 1'b0;
            x_q            <= '0;
            y_q            <= '0;
            z_q            <= '0;
        end else begin
            sample_valid_q <= 1'b0;
            sample_fail_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (sample_tick) begin
                        state_q  <= StReq;
                        rd_req_q <= 1'b1;
                        retry_q  <= '0;
                        timer_q  <= '0;
                    end
                end
                StReq, StWait: begin
                    if (attempt_failed) begin
                        if (retries_left) begin
                            state_q  <= StReq;
                            rd_req_q <= 1'b1;
                            retry_q  <= retry_q + RTY_W'(1);
                            timer_q  <= '0;
                        end else begin
                            state_q       <= StIdle;
                            rd_req_q      <= 1'b0;
                            sample_fail_q <= 1'b1;
                        end
                    end else if ((state_q == StReq) && rd_ack) begin
                        state_q  <= StWait;
                        rd_req_q <= 1'b0;
                        timer_q  <= '0;
                    end else if (capture) begin
                        // Output registers load here so the triple is visible during LATCH.
                        state_q        <= StLatch;
                        sample_valid_q <= 1'b1;
                        x_q            <= x_new;
                        y_q            <= y_new;
                        z_q            <= z_new;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                StLatch: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_overrun_cnt (
        .clk  (clk),
        .clear(rst),
        .inc  (overrun_inc),
        .count(overrun_cnt)
    );

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_fault_cnt (
        .clk  (clk),
        .clear(rst),
        .inc  (fault_inc),
        .count(fault_cnt)
    );

    assign rd_req       = rd_req_q;
    assign sample_valid = sample_valid_q;
    assign sample_fail  = sample_fail_q;
    assign busy         = (state_q != StIdle);
    assign x_out        = x_q;
    assign y_out        = y_q;
    assign z_out        = z_q;

endmodule
